// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a dual-port SRAM: registered write port, show-ahead output register.
// Define SRAM_FIFO_LEVEL_EN to add the `level` occupancy output.
module sram_fifo_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_din,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [WIDTH-1:0]      rd_dout
`ifdef SRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]      wr_din_q, wr_din_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;

    logic [ADDR_WIDTH:0]   occupied;
    logic                  push;
    logic                  load;

    // A pending write already owns its SRAM entry, so it counts against capacity.
    assign occupied = mem_count_q + {{ADDR_WIDTH{1'b0}}, wr_en_q};
    assign in_ready = occupied < DEPTH_C;
    assign push     = in_valid && in_ready;
    // Only committed entries are loaded; the word being written this cycle is not yet counted.
    assign load     = (mem_count_q != '0) && (!out_valid_q || out_ready);

    assign rd_en     = load;
    assign rd_addr   = rd_ptr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_din    = wr_din_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SRAM_FIFO_LEVEL_EN
    assign level = occupied + {{ADDR_WIDTH{1'b0}}, out_valid_q};
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_din_d    = wr_din_q;
        wr_en_d     = push;
        if (push) begin
            wr_addr_d = wr_ptr_q;
            wr_din_d  = in_data;
            wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_data_d  = rd_dout;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        mem_count_d = mem_count_q;
        case ({wr_en_q, load})
            2'b10:   mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   mem_count_d = mem_count_q - (ADDR_WIDTH+1)'(1);
            default: mem_count_d = mem_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_din_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_din_q    <= wr_din_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural dual-port SRAM.
module tb_sram_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_din;
    logic [AW-1:0]    rd_addr;
    logic             rd_en;
    logic [WIDTH-1:0] rd_dout;
`ifdef SRAM_FIFO_LEVEL_EN
    logic [AW:0]      level;
`endif

    sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_din(wr_din),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_dout(rd_dout)
`ifdef SRAM_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge clk) if (wr_en) sram[wr_addr] <= wr_din;
    assign rd_dout = rd_en ? sram[rd_addr] : 'x;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    logic [WIDTH-1:0] sb[$];
    logic [AW-1:0]    wptr_m = '0;
    logic             pend_w = 1'b0;
    logic [AW-1:0]    exp_waddr = '0;
    logic [WIDTH-1:0] exp_wdin = '0;

    // Mid-cycle monitor: registered write port vs. model, then handshakes for this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            wptr_m = '0;
            pend_w = 1'b0;
        end else begin
            check_eq("mon_wr_en", {31'd0, wr_en}, {31'd0, pend_w});
            if (pend_w) begin
                check_eq("mon_wr_addr", {28'd0, wr_addr}, {28'd0, exp_waddr});
                check_eq("mon_wr_din", {24'd0, wr_din}, {24'd0, exp_wdin});
            end
`ifdef SRAM_FIFO_LEVEL_EN
            check_eq("mon_level", {27'd0, level}, sb.size());
`endif
            pend_w = in_valid && in_ready;
            if (pend_w) begin
                exp_waddr = wptr_m;
                exp_wdin  = in_data;
                wptr_m    = wptr_m + 4'd1;
                sb.push_back(in_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check_eq("pop_empty_sb", 32'd1, 32'd0);
                else                check_eq("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
        check_eq(tag, sb.size(), 32'd0);
        check_eq({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    int n_valid;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_eq("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check_eq("rst_wr_din", {24'd0, wr_din}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Single word latency.
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        check_eq("t1_wr_en", {31'd0, wr_en}, 32'd1);
        check_eq("t1_wr_addr", {28'd0, wr_addr}, 32'd0);
        tick();
        check_eq("t1_rd_en", {31'd0, rd_en}, 32'd1);
        check_eq("t1_ov_early", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("t1_ov", {31'd0, out_valid}, 32'd1);
        check_eq("t1_od", {24'd0, out_data}, 32'h0000_00A5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t1_ov_drop", {31'd0, out_valid}, 32'd0);

        // Fill to capacity: 16 SRAM entries plus the output register.
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            check_eq("fill_rdy", {31'd0, in_ready}, 32'd1);
            tick();
        end
        check_eq("full_rdy", {31'd0, in_ready}, 32'd0);
        in_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("full_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check_eq("full_wr_en", {31'd0, wr_en}, 32'd0);
`ifdef SRAM_FIFO_LEVEL_EN
        check_eq("full_level", {27'd0, level}, 32'd17);
`endif

        // Pop frees an entry; then pop and push in the same cycle.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("rdy_after_pop", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        drain("drain1");
        for (int i = 0; i < 4; i++) begin
            check_eq("empty_rd_en", {31'd0, rd_en}, 32'd0);
            tick();
        end

        // Streaming: one push and one pop per cycle, pointers wrap.
        in_valid = 1'b1; out_ready = 1'b1; n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            in_data = WIDTH'(8'h40 + i);
            if (out_valid) n_valid++;
            tick();
        end
        in_valid = 1'b0;
        check_eq("stream_cont", n_valid, 32'd37);
        drain("drain2");

        // Asynchronous reset mid-stream.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(8'h90 + i);
            tick();
        end
        in_valid = 1'b0;
        check_eq("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
        check_eq("pre_rst_ov", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wr_en", {31'd0, wr_en}, 32'd0);
        check_eq("arst_ov", {31'd0, out_valid}, 32'd0);
`ifdef SRAM_FIFO_LEVEL_EN
        check_eq("arst_level", {27'd0, level}, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_wr_en", {31'd0, wr_en}, 32'd1);
        check_eq("post_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        tick();
        tick();
        check_eq("post_rst_od", {24'd0, out_data}, 32'h0000_003C);
        drain("drain3");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Synchronous FIFO controller that drives the dual-port `SRAM` macro's write and read ports. It converts a valid/ready push stream into registered, glitch-free SRAM writes. It also converts SRAM reads into a registered show-ahead valid/ready pop stream. It sits directly in front of `SRAM` and owns all pointer, occupancy and flow-control state.

## Interface
Parameters:
- `WIDTH`, 8, data word width; must match `SRAM.WIDTH`.
- `DEPTH`, 16, SRAM entries; must equal 2**`ADDR_WIDTH`.
- `ADDR_WIDTH`, 4, SRAM address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  controller can accept a push.
- `in_data`  in  WIDTH  push data.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  WIDTH  head-of-FIFO word (registered).
- `wr_addr`  out  ADDR_WIDTH  SRAM write address (registered).
- `wr_en`  out  1  SRAM write enable (registered).
- `wr_din`  out  WIDTH  SRAM write data (registered).
- `rd_addr`  out  ADDR_WIDTH  SRAM read address (equals read pointer).
- `rd_en`  out  1  SRAM read enable.
- `rd_dout`  in  WIDTH  SRAM read data.
- `level`  out  ADDR_WIDTH+1  entry count; present only with `SRAM_FIFO_LEVEL_EN`.

## Operation
- Push accept: `in_valid && in_ready` at a clock edge.
  - Registers `wr_addr`=wr_ptr, `wr_din`=`in_data` and `wr_en`=1 for exactly the next cycle.
  - wr_ptr increments.
- `wr_en`, `wr_addr` and `wr_din` only change on clock edges and are never combinational. This keeps the level-sensitive SRAM write clean.
- `mem_count` counts committed SRAM entries. It increments on the edge that ends a cycle with `wr_en`=1.
- `wr_pend` = current `wr_en`.
- `in_ready` = (`mem_count` + `wr_pend`) < DEPTH. It is combinational from registers and independent of `in_valid`.
- Load condition: `mem_count` > 0 and (!`out_valid` or `out_ready`).
  - `rd_en` = load condition (combinational).
  - At the edge with load: `out_data` <= `rd_dout`, `out_valid` <= 1, rd_ptr increments, `mem_count` decrements.
- Pop without load (`out_valid && out_ready`, `mem_count`==0): `out_valid` <= 0.
- `rd_addr` = rd_ptr at all times. When `rd_en`=0, `rd_dout` is X and ignored.
- Pointers wrap DEPTH-1 -> 0 by natural ADDR_WIDTH overflow.
- Simultaneous write commit and load in one edge: `mem_count` is unchanged (+1 -1).
- A load never reads the entry being written in the same cycle. Only committed entries are readable.
- Total capacity = DEPTH (SRAM) + 1 (output register).
- Pushes with `in_ready`=0 are ignored; no state changes.

## Timing
- Reset (async assert, sync-safe deassert by system) values: `wr_en`=0, `wr_addr`=0, `wr_din`=0, `out_valid`=0, `out_data`=0, pointers=0, `mem_count`=0.
  - `rd_en`=0 and `in_ready`=1 follow from reset state.
  - `level`=0.
- Reset mid-operation discards all contents immediately; `wr_en` drops without waiting for a clock.
- Empty-to-first-word latency: push accepted at edge E0 -> `wr_en` high E0..E1 -> `rd_en` high E1..E2 -> `out_valid`=1 after E2 (2 cycles).
- Steady state: 1 push and 1 pop per cycle sustained when non-empty and non-full.
- SRAM read delay (~1ns) and write delay (~1ns) must fit within one clock period. The minimum clock period is above 2ns.

## Configuration
- `SRAM_FIFO_LEVEL_EN` defined:
  - Adds output `level` = `mem_count` + `wr_pend` + `out_valid`, registered-source combinational, range 0..DEPTH+1.
- `SRAM_FIFO_LEVEL_EN` undefined:
  - The `level` port does not exist.
  - All other behaviour is identical.

## Test plan
- Reset, then push 0xA5 with `out_ready`=0.
  - `wr_en`=1 with `wr_addr`=0 one cycle later.
  - `out_valid`=1 with `out_data`=0xA5 two cycles after the push edge.
- Push 17 words 0x00..0x10 with `out_ready`=0.
  - `in_ready` falls after the 17th accept.
  - `level`=17 (LEVEL_EN).
  - An 18th push is ignored.
- Hold `in_valid`=1 and `out_ready`=1 for 40 cycles with incrementing data.
  - The output sequence is in order with no gaps after 2-cycle fill.
  - Pointers wrap past 15 -> 0.
- Fill to 17 words, then pop 1 and push 1 in the same cycle.
  - FIFO order is preserved.
  - `in_ready` re-asserts the cycle after the pop frees an SRAM entry.
- Drain to empty.
  - `out_valid` drops right after the last pop.
  - `rd_en` stays 0 while `mem_count`=0.
- Assert `rst_n`=0 mid-stream with `wr_en`=1.
  - `wr_en`, `out_valid` and `level` go to 0 without a clock edge.
  - After release, the next push reappears at `wr_addr`=0.
